// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - op, writeback and redirect channels of the branch resolve stage
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic [4:0]      in_rd;
  logic            in_cmp_result;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;
  logic            out_valid;
  logic            out_ready;
  logic            out_wen;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_link;
  logic            out_misalign;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     mispred_count;

  modport slave (
    input  in_valid, in_kind, in_pc, in_imm, in_rs1, in_rd, in_cmp_result,
           in_pred_taken, in_pred_target, out_ready, redirect_ready,
    output in_ready, out_valid, out_wen, out_rd, out_link, out_misalign,
           redirect_valid, redirect_pc, mispred_count
  );

  modport master (
    output in_valid, in_kind, in_pc, in_imm, in_rs1, in_rd, in_cmp_result,
           in_pred_taken, in_pred_target, out_ready, redirect_ready,
    input  in_ready, out_valid, out_wen, out_rd, out_link, out_misalign,
           redirect_valid, redirect_pc, mispred_count
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves branches/jumps, flags mispredicts, redirects fetch, squashes wrong path
module branch_resolve #(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input logic             clk,
  input logic             reset_n,
  branch_resolve_if.slave bus
);
  localparam logic [1:0] K_JAL  = 2'd1;
  localparam logic [1:0] K_JALR = 2'd2;
  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_SQUASH} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      squash_cnt;

  logic            out_valid_q;
  logic            out_wen_q;
  logic [4:0]      out_rd_q;
  logic [XLEN-1:0] out_link_q;
  logic            out_misalign_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [31:0]     mispred_q;

  logic            is_jump;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            mispredict;
  logic            in_ready_c;
  logic            accept;
  logic            redir_hs;

  // Reserved kind 3 falls through as a conditional branch.
  always_comb begin
    is_jump    = (bus.in_kind == K_JAL) || (bus.in_kind == K_JALR);
    taken      = is_jump | bus.in_cmp_result;
    jalr_sum   = bus.in_rs1 + bus.in_imm;
    target     = (bus.in_kind == K_JALR) ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                         : (bus.in_pc + bus.in_imm);
    seq_pc     = bus.in_pc + XLEN'(4);
    next_pc    = taken ? target : seq_pc;
    misalign   = taken & (target[1:0] != 2'b00);
    mispredict = !misalign &
                 ((bus.in_pred_taken != taken) | (taken & (bus.in_pred_target != target)));
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      S_RUN: begin
        in_ready_c = !out_valid_q | bus.out_ready;
        if (bus.in_valid && in_ready_c && mispredict) state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) state_nxt = (SQUASH_CYCLES == 0) ? S_RUN : S_SQUASH;
      end
      S_SQUASH: begin
        in_ready_c = 1'b1;
        if (squash_cnt <= 4'd1) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign accept   = (state == S_RUN) & bus.in_valid & in_ready_c;
  assign redir_hs = (state == S_REDIRECT) & bus.redirect_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_cnt <= 4'd0;
    end else if (redir_hs) begin
      squash_cnt <= SQ_LOAD;
    end else if (state == S_SQUASH && squash_cnt != 4'd0) begin
      squash_cnt <= squash_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_wen_q      <= 1'b0;
      out_rd_q       <= 5'd0;
      out_link_q     <= '0;
      out_misalign_q <= 1'b0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_wen_q      <= is_jump & (bus.in_rd != 5'd0) & !misalign;
      out_rd_q       <= bus.in_rd;
      out_link_q     <= seq_pc;
      out_misalign_q <= misalign;
    end else if (bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  // Misaligned targets never reach here as mispredicts; the trap travels with the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mispred_q        <= 32'd0;
    end else if (accept && mispredict) begin
      redirect_valid_q <= 1'b1;
      redirect_pc_q    <= next_pc;
      if (mispred_q != 32'hFFFF_FFFF) mispred_q <= mispred_q + 32'd1;
    end else if (redir_hs) begin
      redirect_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_wen        = out_wen_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_link       = out_link_q;
  assign bus.out_misalign   = out_misalign_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mispred_count  = mispred_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed vector table plus hand sequences for branch_resolve
module tb_branch_resolve;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bus ();

  branch_resolve #(.XLEN(32), .SQUASH_CYCLES(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [4:0]  rd;
    logic        cmp;
    logic        pt;
    logic [31:0] ptgt;
    logic        wen;
    logic        mis;
    logic        redir;
    logic [31:0] link;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [4:0] rd, input logic cmp,
                       input logic pt, input logic [31:0] ptgt);
    bus.in_valid       = 1'b1;
    bus.in_kind        = kind;
    bus.in_pc          = pc;
    bus.in_imm         = imm;
    bus.in_rs1         = rs1;
    bus.in_rd          = rd;
    bus.in_cmp_result  = cmp;
    bus.in_pred_taken  = pt;
    bus.in_pred_target = ptgt;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_kind = 2'd0;
    bus.in_pc = 32'd0;
    bus.in_imm = 32'd0;
    bus.in_rs1 = 32'd0;
    bus.in_rd = 5'd0;
    bus.in_cmp_result = 1'b0;
    bus.in_pred_taken = 1'b0;
    bus.in_pred_target = 32'd0;
    bus.out_ready = 1'b1;
    bus.redirect_ready = 1'b1;

    //        kind   pc            imm           rs1          rd    cmp   pt    ptgt          wen   mis   redir link          rpc
    vecs[0]  = '{2'd0, 32'h100,      32'h20,       32'h0,       5'd0, 1'b1, 1'b1, 32'h120,      1'b0, 1'b0, 1'b0, 32'h104,      32'h0};
    vecs[1]  = '{2'd2, 32'h300,      32'h4,        32'h1003,    5'd1, 1'b0, 1'b1, 32'h1000,     1'b0, 1'b1, 1'b0, 32'h304,      32'h0};
    vecs[2]  = '{2'd1, 32'h400,      32'h80,       32'h0,       5'd5, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h404,      32'h480};
    vecs[3]  = '{2'd0, 32'h500,      32'h10,       32'h0,       5'd4, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h504,      32'h0};
    vecs[4]  = '{2'd0, 32'h600,      32'h40,       32'h0,       5'd0, 1'b0, 1'b1, 32'h640,      1'b0, 1'b0, 1'b1, 32'h604,      32'h604};
    vecs[5]  = '{2'd0, 32'h700,      32'hFFFFFFF8, 32'h0,       5'd0, 1'b1, 1'b1, 32'h708,      1'b0, 1'b0, 1'b1, 32'h704,      32'h6F8};
    vecs[6]  = '{2'd1, 32'h800,      32'h100,      32'h0,       5'd0, 1'b0, 1'b1, 32'h900,      1'b0, 1'b0, 1'b0, 32'h804,      32'h0};
    vecs[7]  = '{2'd3, 32'h900,      32'h20,       32'h0,       5'd3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h904,      32'h0};
    vecs[8]  = '{2'd2, 32'hA00,      32'h10,       32'h2000,    5'd31,1'b0, 1'b1, 32'h2010,     1'b1, 1'b0, 1'b0, 32'hA04,      32'h0};
    vecs[9]  = '{2'd0, 32'hB00,      32'h2,        32'h0,       5'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hB04,      32'h0};
    vecs[10] = '{2'd2, 32'hC00,      32'h0,        32'h3001,    5'd2, 1'b0, 1'b1, 32'h3000,     1'b1, 1'b0, 1'b0, 32'hC04,      32'h0};
    vecs[11] = '{2'd0, 32'hFFFFFFFC, 32'h40,       32'h0,       5'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("rst_misalign", {31'd0, bus.out_misalign}, 32'd0);
    chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_link", bus.out_link, 32'd0);
    chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("rst_count", bus.mispred_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single ops
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rd,
            vecs[i].cmp, vecs[i].pt, vecs[i].ptgt);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (vecs[i].redir) exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_out_wen", i), {31'd0, bus.out_wen}, {31'd0, vecs[i].wen});
      chk($sformatf("v%0d_out_rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_out_link", i), bus.out_link, vecs[i].link);
      chk($sformatf("v%0d_misalign", i), {31'd0, bus.out_misalign}, {31'd0, vecs[i].mis});
      chk($sformatf("v%0d_redirect_valid", i), {31'd0, bus.redirect_valid}, {31'd0, vecs[i].redir});
      if (vecs[i].redir) chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].rpc);
      chk($sformatf("v%0d_count", i), bus.mispred_count, exp_cnt);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_idle_out_valid", i), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("v%0d_idle_redirect", i), {31'd0, bus.redirect_valid}, 32'd0);
    end

    // Redirect held under redirect_ready=0, then exactly two squashed inputs
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    drive(2'd0, 32'h200, 32'h40, 32'h0, 5'd0, 1'b0, 1'b1, 32'h240);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("bne_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("bne_redirect_pc", bus.redirect_pc, 32'h204);
    chk("bne_count", bus.mispred_count, exp_cnt);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_redirect_valid", c), {31'd0, bus.redirect_valid}, 32'd1);
      chk($sformatf("hold%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("hold%0d_redirect_pc", c), bus.redirect_pc, 32'h204);
    end
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk("hs_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("squash_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(2'd1, 32'h440, 32'h20, 32'h0, 5'd6, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("squash%0d_out_valid", c), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("squash%0d_redirect", c), {31'd0, bus.redirect_valid}, 32'd0);
      chk($sformatf("squash%0d_count", c), bus.mispred_count, exp_cnt);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("post_squash_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_squash_link", bus.out_link, 32'h444);
    chk("post_squash_redirect_pc", bus.redirect_pc, 32'h460);
    chk("post_squash_count", bus.mispred_count, exp_cnt);
    repeat (4) @(negedge clk);

    // Output backpressure, mispredict accepted as out_ready rises
    bus.out_ready = 1'b0;
    drive(2'd0, 32'h100, 32'h20, 32'h0, 5'd0, 1'b1, 1'b1, 32'h120);
    @(negedge clk);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(2'd1, 32'h1400, 32'h100, 32'h0, 5'd7, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_hold_link", bus.out_link, 32'h104);
    chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("bp_rise_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_rise_link", bus.out_link, 32'h1404);
    chk("bp_rise_wen", {31'd0, bus.out_wen}, 32'd1);
    chk("bp_rise_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("bp_rise_redirect_pc", bus.redirect_pc, 32'h1500);
    chk("bp_rise_count", bus.mispred_count, exp_cnt);
    repeat (4) @(negedge clk);

    // Asynchronous reset while a redirect is pending
    bus.redirect_ready = 1'b0;
    drive(2'd1, 32'h400, 32'h80, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("arst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("arst_link", bus.out_link, 32'd0);
    chk("arst_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("arst_count", bus.mispred_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    drive(2'd0, 32'h100, 32'h20, 32'h0, 5'd0, 1'b1, 1'b1, 32'h120);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_rst_link", bus.out_link, 32'h104);
    repeat (2) @(negedge clk);

    // Counter saturation
    force dut.mispred_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.mispred_q;
    chk("sat_preload", bus.mispred_count, 32'hFFFF_FFFF);
    drive(2'd1, 32'h400, 32'h80, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sat_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("sat_count", bus.mispred_count, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
